// File: rtl/snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// snake_dir_ctrl
//   Direction controller for the snake game. It takes the single-cycle press
//   pulses from the four button debouncers and rejects 180-degree reversals
//   and repeated directions. Accepted turns wait in a small circular queue.
//   Each game tick commits at most one queued turn to o_dir.
//
// Parameters
//   QDEPTH    pending-turn queue depth (1..4)
//   INIT_DIR  direction loaded at reset and on restart
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_press_up/right/
//   i_press_down/left     single-cycle press pulses (priority up > right > down > left)
//   i_tick                single-cycle game-step strobe
//   i_game_en             level, high while the game runs
//   i_restart             single-cycle pulse, reloads INIT_DIR and flushes the queue
//   o_dir                 committed direction (00 up, 01 right, 10 down, 11 left)
//   o_step                one-cycle pulse after a processed tick
//   o_turn                one-cycle pulse after a tick that changed o_dir
//   o_drop                one-cycle pulse after a legal press was lost to a full queue
//   o_pending             number of queued turns
// -----------------------------------------------------------------------------
module snake_dir_ctrl #(
  parameter int         QDEPTH   = 2,
  parameter logic [1:0] INIT_DIR = 2'b01
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_press_up,
  input  logic       i_press_right,
  input  logic       i_press_down,
  input  logic       i_press_left,
  input  logic       i_tick,
  input  logic       i_game_en,
  input  logic       i_restart,
  output logic [1:0] o_dir,
  output logic       o_step,
  output logic       o_turn,
  output logic       o_drop,
  output logic [2:0] o_pending
);

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_RIGHT = 2'b01;
  localparam logic [1:0] DIR_DOWN  = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam int            PW       = (QDEPTH > 2) ? 2 : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(QDEPTH - 1);
  localparam logic [2:0]    CNT_FULL = 3'(QDEPTH);

  logic [1:0]    q_mem [QDEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr, tail_idx;
  logic [PW-1:0] rd_ptr_nxt, wr_ptr_nxt;
  logic [2:0]    count;

  logic [1:0] cand, ref_dir;
  logic       cand_vld, legal, full, active, flush;
  logic       do_push, do_pop, do_drop, do_tick;

  // Press arbitration, legality and queue control
  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    cand_vld = i_press_up | i_press_right | i_press_down | i_press_left;
    cand     = DIR_LEFT;
    if      (i_press_up)    cand = DIR_UP;
    else if (i_press_right) cand = DIR_RIGHT;
    else if (i_press_down)  cand = DIR_DOWN;

    rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);
    wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
    tail_idx   = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PW'(1);

    // Legality is judged against the last direction the snake will take:
    // the newest queued turn, or the committed one if nothing is queued.
    ref_dir = (count != 3'd0) ? q_mem[tail_idx] : o_dir;
    legal   = cand_vld && (cand != ref_dir) && (cand != (ref_dir ^ 2'b10));
    full    = (count == CNT_FULL);

    active  = i_game_en && !i_restart;
    flush   = i_restart || !i_game_en;
    do_push = active && legal && !full;
    do_drop = active && legal && full;
    do_tick = active && i_tick;
    do_pop  = do_tick && (count != 3'd0);
  end

  // Control state and registered outputs
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_dir  <= INIT_DIR;
      o_step <= 1'b0;
      o_turn <= 1'b0;
      o_drop <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= 3'd0;
    end else begin
      o_step <= do_tick;
      o_turn <= do_pop;
      o_drop <= do_drop;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= 3'd0;
        if (i_restart) o_dir <= INIT_DIR;
      end else begin
        if (do_push) wr_ptr <= wr_ptr_nxt;
        // The pop reads pre-push contents, so a press arriving into an
        // empty queue is committed no earlier than the next tick.
        if (do_pop) begin
          rd_ptr <= rd_ptr_nxt;
          o_dir  <= q_mem[rd_ptr];
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // NOTE: the queue storage has no reset; occupancy and pointers alone decide
  // which entries are meaningful, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (do_push) q_mem[wr_ptr] <= cand;
  end

  assign o_pending = count;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// -----------------------------------------------------------------------------
// tb_snake_dir_ctrl
//   Directed bench for snake_dir_ctrl (QDEPTH = 2, INIT_DIR = 01). Each
//   stimulus cycle pushes the hand-computed expected outputs into a
//   scoreboard; a monitor pops and compares on the following falling edge.
// -----------------------------------------------------------------------------
module tb_snake_dir_ctrl;

  typedef struct packed {
    logic [1:0] dir;
    logic       step;
    logic       turn;
    logic       drop;
    logic [2:0] pend;
  } obs_t;

  logic       i_clk = 1'b0;
  logic       i_rst_n;
  logic       i_press_up, i_press_right, i_press_down, i_press_left;
  logic       i_tick, i_game_en, i_restart;
  logic [1:0] o_dir;
  logic       o_step, o_turn, o_drop;
  logic [2:0] o_pending;

  int n_checks = 0;
  int n_fail   = 0;

  obs_t  sb_exp [$];
  string sb_tag [$];

  snake_dir_ctrl #(.QDEPTH(2), .INIT_DIR(2'b01)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_press_up    (i_press_up),
    .i_press_right (i_press_right),
    .i_press_down  (i_press_down),
    .i_press_left  (i_press_left),
    .i_tick        (i_tick),
    .i_game_en     (i_game_en),
    .i_restart     (i_restart),
    .o_dir         (o_dir),
    .o_step        (o_step),
    .o_turn        (o_turn),
    .o_drop        (o_drop),
    .o_pending     (o_pending)
  );

  always #5 i_clk = ~i_clk;

  function automatic obs_t observe();
    obs_t o;
    o.dir  = o_dir;
    o.step = o_step;
    o.turn = o_turn;
    o.drop = o_drop;
    o.pend = o_pending;
    return o;
  endfunction

  task automatic check(input string name, input obs_t act, input obs_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got dir=%b step=%b turn=%b drop=%b pend=%0d, want dir=%b step=%b turn=%b drop=%b pend=%0d",
               name, act.dir, act.step, act.turn, act.drop, act.pend,
               exp.dir, exp.step, exp.turn, exp.drop, exp.pend);
    end
  endtask

  // Monitor: outputs after each rising edge are compared on the falling edge.
  always @(negedge i_clk) begin
    if (sb_exp.size() > 0) begin
      obs_t  e;
      string t;
      e = sb_exp.pop_front();
      t = sb_tag.pop_front();
      check(t, observe(), e);
    end
  end

  // One stimulus cycle. pr = {up, right, down, left}. Expected values are the
  // outputs after the rising edge that samples these inputs.
  task automatic cyc(input string tag, input logic [3:0] pr, input logic tk,
                     input logic en, input logic rs, input logic [1:0] dir,
                     input logic s, input logic t, input logic d,
                     input logic [2:0] p);
    obs_t e;
    @(negedge i_clk);
    #1;
    {i_press_up, i_press_right, i_press_down, i_press_left} = pr;
    i_tick    = tk;
    i_game_en = en;
    i_restart = rs;
    e.dir = dir; e.step = s; e.turn = t; e.drop = d; e.pend = p;
    sb_exp.push_back(e);
    sb_tag.push_back(tag);
  endtask

  task automatic drain();
    int budget = 10;
    @(negedge i_clk);
    #1;
    {i_press_up, i_press_right, i_press_down, i_press_left} = 4'b0;
    i_tick = 1'b0; i_restart = 1'b0;
    while (sb_exp.size() > 0 && budget > 0) begin
      @(negedge i_clk);
      budget--;
    end
    n_checks++;
    if (sb_exp.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left, want 0", sb_exp.size());
    end
  endtask

  localparam logic [3:0] NO = 4'b0000, UP = 4'b1000, RT = 4'b0100,
                         DN = 4'b0010, LT = 4'b0001;

  initial begin
    obs_t rst_exp;
    rst_exp = '{dir: 2'b01, step: 1'b0, turn: 1'b0, drop: 1'b0, pend: 3'd0};

    i_rst_n = 1'b0;
    {i_press_up, i_press_right, i_press_down, i_press_left} = 4'b0;
    i_tick = 1'b0; i_game_en = 1'b1; i_restart = 1'b0;
    #12;
    check("reset", observe(), rst_exp);
    @(negedge i_clk);
    #1 i_rst_n = 1'b1;

    //   tag            press tk en rs  dir   s  t  d  pend
    // Idle ticks with an empty queue
    cyc("idle0",        NO, 0, 1, 0, 2'b01, 0, 0, 0, 3'd0);
    cyc("tick_empty0",  NO, 1, 1, 0, 2'b01, 1, 0, 0, 3'd0);
    cyc("idle1",        NO, 0, 1, 0, 2'b01, 0, 0, 0, 3'd0);
    cyc("tick_empty1",  NO, 1, 1, 0, 2'b01, 1, 0, 0, 3'd0);
    // Legal turn, tick five cycles after the press
    cyc("press_up",     UP, 0, 1, 0, 2'b01, 0, 0, 0, 3'd1);
    for (int i = 0; i < 4; i++)
      cyc("wait_tick",  NO, 0, 1, 0, 2'b01, 0, 0, 0, 3'd1);
    cyc("tick_turn",    NO, 1, 1, 0, 2'b00, 1, 1, 0, 3'd0);
    cyc("after_turn",   NO, 0, 1, 0, 2'b00, 0, 0, 0, 3'd0);
    // Restart, then reversal and repeat rejection
    cyc("restart0",     NO, 0, 1, 1, 2'b01, 0, 0, 0, 3'd0);
    cyc("reverse",      LT, 0, 1, 0, 2'b01, 0, 0, 0, 3'd0);
    cyc("repeat",       RT, 0, 1, 0, 2'b01, 0, 0, 0, 3'd0);
    // Double turn and overflow
    cyc("q_up",         UP, 0, 1, 0, 2'b01, 0, 0, 0, 3'd1);
    cyc("q_left",       LT, 0, 1, 0, 2'b01, 0, 0, 0, 3'd2);
    cyc("q_down_drop",  DN, 0, 1, 0, 2'b01, 0, 0, 1, 3'd2);
    cyc("drop_clear",   NO, 0, 1, 0, 2'b01, 0, 0, 0, 3'd2);
    cyc("pop_up",       NO, 1, 1, 0, 2'b00, 1, 1, 0, 3'd1);
    cyc("pop_left",     NO, 1, 1, 0, 2'b11, 1, 1, 0, 3'd0);
    cyc("tick_hold",    NO, 1, 1, 0, 2'b11, 1, 0, 0, 3'd0);
    // Simultaneous presses and press-with-tick
    cyc("restart1",     NO, 0, 1, 1, 2'b01, 0, 0, 0, 3'd0);
    cyc("up_and_left",  UP|LT, 0, 1, 0, 2'b01, 0, 0, 0, 3'd1);
    cyc("idle2",        NO, 0, 1, 0, 2'b01, 0, 0, 0, 3'd1);
    cyc("left_w_tick",  LT, 1, 1, 0, 2'b00, 1, 1, 0, 3'd1);
    cyc("pop_left2",    NO, 1, 1, 0, 2'b11, 1, 1, 0, 3'd0);
    // Restart with two turns queued, press and tick ignored
    cyc("restart2",     NO, 0, 1, 1, 2'b01, 0, 0, 0, 3'd0);
    cyc("q_up2",        UP, 0, 1, 0, 2'b01, 0, 0, 0, 3'd1);
    cyc("q_left2",      LT, 0, 1, 0, 2'b01, 0, 0, 0, 3'd2);
    cyc("restart_tick", DN, 1, 1, 1, 2'b01, 0, 0, 0, 3'd0);
    // Game disabled flushes the queue and ignores ticks/presses
    cyc("q_up3",        UP, 0, 1, 0, 2'b01, 0, 0, 0, 3'd1);
    cyc("disable_tick", NO, 1, 0, 0, 2'b01, 0, 0, 0, 3'd0);
    cyc("disable_prs",  UP, 1, 0, 0, 2'b01, 0, 0, 0, 3'd0);
    cyc("reenable",     NO, 1, 1, 0, 2'b01, 1, 0, 0, 3'd0);
    // Full queue: press is dropped while the same tick pops
    cyc("q_up4",        UP, 0, 1, 0, 2'b01, 0, 0, 0, 3'd1);
    cyc("q_left4",      LT, 0, 1, 0, 2'b01, 0, 0, 0, 3'd2);
    cyc("full_drop_pop",DN, 1, 1, 0, 2'b00, 1, 1, 1, 3'd1);
    cyc("pop_left4",    NO, 1, 1, 0, 2'b11, 1, 1, 0, 3'd0);
    drain();

    // Asynchronous reset mid-operation
    cyc("q_down5",      DN, 0, 1, 0, 2'b11, 0, 0, 0, 3'd1);
    drain();
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1 check("async_reset", observe(), rst_exp);
    @(negedge i_clk);
    #1 i_rst_n = 1'b1;
    cyc("post_reset",   RT, 1, 1, 0, 2'b01, 1, 0, 0, 3'd0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
